i2c_slave: RTL and testbench
============================

# i2c_slave

Target-side I2C endpoint that pairs with the team's `i2c_master`. It oversamples SCL and SDA on the system clock and detects START, repeated START and STOP. It matches a fixed 7-bit address, ACKs and delivers written bytes, and serves read bytes from a user data port. SDA is driven open-drain, low only; SCL is input-only, and the block never stretches the clock.

## Interface
- `SLAVE_ADDR`, default 7'h50: 7-bit address this target responds to.
- `clk`  input  1: system clock; must run at ≥8× the SCL frequency.
- `reset`  input  1: asynchronous, active-high reset.
- `i2c_scl`  input  1: bus clock from the master.
- `i2c_sda`  inout  1: bus data; driven `1'b0` when `sda_oe`=1, else `'bz`.
- `rx_data`  output  8: last byte written by the master; valid while `rx_valid`=1.
- `rx_valid`  output  1: one-cycle pulse per received write byte.
- `tx_data`  input  8: byte to return on a read; captured when `tx_req` pulses.
- `tx_req`  output  1: one-cycle pulse; `tx_data` is latched in that same cycle.
- `busy`  output  1: high from an address-matched START until STOP.

## Operation
- Input path: 2-flop synchronizer on SCL and SDA, plus one history flop for edge detection.
- START: SDA falls while SCL is high → go to ADDR and clear the bit counter. A repeated START in any state behaves the same.
- STOP: SDA rises while SCL is high → go to IDLE from any state, release SDA, drop `busy`.
- SDA sampling: on the synchronized SCL rising edge, shift MSB-first into an 8-bit shift register.
- SDA drive changes: only on the synchronized SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: 8 bits in; the 8th bit is R/W. If `addr[7:1]`==`SLAVE_ADDR`, go to ADDR_ACK and set `busy`; otherwise go to WAIT_STOP.
  - ADDR_ACK: pull SDA low for the 9th clock. If R/W=1, pulse `tx_req` at entry and go to READ; if R/W=0, go to WRITE.
  - WRITE: 8 bits in; on the 8th rising edge, load `rx_data` and pulse `rx_valid`, then go to WRITE_ACK.
  - WRITE_ACK: always ACK (SDA low for the 9th clock), then return to WRITE.
  - READ: shift the latched byte out MSB-first, placing bit 7 on the falling edge that ends the ACK, then go to READ_ACK.
  - READ_ACK: release SDA and sample the master's bit on the 9th rising edge. ACK (0): pulse `tx_req` and go to READ. NACK (1): go to WAIT_STOP.
  - WAIT_STOP: SDA released; only START or STOP leave this state.
- Reset values: `sda_oe`=0, `rx_data`=8'h00, `rx_valid`=0, `tx_req`=0, `busy`=0, state=IDLE.

## Timing
- Input latency: 2 `clk` from a pin change to the synchronized value, plus 1 more for edge detection. A bus event is therefore acted on 3 `clk` after the pin changes.
- `rx_valid` asserts 3 `clk` after the SCL rising edge that carries data bit 0.
- ACK drive begins 3 `clk` after the 8th SCL falling edge and releases 3 `clk` after the 9th falling edge.
- `tx_req` in the ADDR_ACK case: asserted in the cycle the block enters ADDR_ACK, so `tx_data` must be stable by then.
- `tx_req` in the read-continue case: asserted 3 `clk` after the 9th rising edge when the master ACKs.
- Simultaneous START/STOP and a bit edge in the same cycle: START/STOP wins.
- Asynchronous reset mid-transfer: SDA is released immediately and not re-driven until the next START.
- Address mismatch: SDA is never driven and `busy` stays low.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN` defined: a 3-sample majority filter follows each synchronizer. Pulses ≤1 `clk` wide are rejected, and every latency above grows by 2 `clk`. The `clk` requirement rises to ≥12× SCL.
- Undefined: no filter; latencies exactly as stated under Timing.

## Test plan
- Write to 0x50 with data 8'hA5 → ACK on address, `rx_valid` one pulse with `rx_data`=8'hA5, data byte ACKed, `busy` drops after STOP.
- Address 0x51 with `SLAVE_ADDR`=0x50 → SDA never driven, no `rx_valid`, `busy` stays 0, state returns to IDLE on STOP.
- Read from 0x50 with `tx_data`=8'h3C, master ACKs, then `tx_data`=8'hC3 with master NACK → bus carries 3C then C3, exactly two `tx_req` pulses, SDA released afterwards.
- Write 8'h12, then repeated START, then read with `tx_data`=8'h77 → `rx_data`=8'h12, then 8'h77 returned, `busy` held high throughout.
- Assert `reset` during the 4th data bit of a write → `sda_oe`=0 immediately, no `rx_valid`; the next full write of 8'h5A succeeds.
- With `I2C_SLAVE_GLITCH_FILTER_EN` defined, inject a 1-`clk` SDA low glitch while SCL is high in IDLE → no START detected, `busy` stays 0.

Source files
------------

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target with a fixed 7-bit address, open-drain SDA, no clock stretching.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL and SDA.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP} state_t;
  state_t state, state_n;
  logic [1:0] scl_s, sda_s;
  logic       scl, sda, scl_d, sda_d;
  logic [3:0] cnt, cnt_n;
  logic [7:0] shreg, shreg_n, tx_shift, tx_shift_n, rx_data_n;
  logic       sda_oe, sda_oe_n, rx_valid_n, tx_req_n, busy_n, rw, rw_n;
  logic       scl_rise, scl_fall, start, stop;

  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scl_s <= 2'b11;
      sda_s <= 2'b11;
    end else begin
      scl_s <= {scl_s[0], i2c_scl};
      sda_s <= {sda_s[0], i2c_sda};
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [2:0] scl_f, sda_f;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      scl_f <= 3'b111;
      sda_f <= 3'b111;
    end else begin
      scl_f <= {scl_f[1:0], scl_s[1]};
      sda_f <= {sda_f[1:0], sda_s[1]};
    end
  assign scl = (scl_f[0] & scl_f[1]) | (scl_f[0] & scl_f[2]) | (scl_f[1] & scl_f[2]);
  assign sda = (sda_f[0] & sda_f[1]) | (sda_f[0] & sda_f[2]) | (sda_f[1] & sda_f[2]);
`else
  assign scl = scl_s[1];
  assign sda = sda_s[1];
`endif

  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign start    = scl & scl_d & sda_d & ~sda;
  assign stop     = scl & scl_d & ~sda_d & sda;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      cnt      <= 4'd0;
      shreg    <= 8'h00;
      tx_shift <= 8'h00;
      rw       <= 1'b0;
      sda_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      scl_d    <= scl;
      sda_d    <= sda;
      cnt      <= cnt_n;
      shreg    <= shreg_n;
      tx_shift <= tx_shift_n;
      rw       <= rw_n;
      sda_oe   <= sda_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      busy     <= busy_n;
    end

  // cnt counts SCL rising edges per byte; 9 in READ marks "load bit 7 on the next fall"
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shreg_n    = shreg;
    rw_n       = rw;
    tx_shift_n = tx_req ? tx_data : tx_shift;
    rx_data_n  = rx_data;
    sda_oe_n   = sda_oe;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy;
    if (stop) begin
      state_n  = IDLE;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
    end else if (start) begin
      state_n  = ADDR;
      cnt_n    = 4'd0;
      sda_oe_n = 1'b0;
    end else if (scl_rise) begin
      shreg_n = {shreg[6:0], sda};
      cnt_n   = cnt + 4'd1;
      case (state)
        ADDR: if (cnt == 4'd7) begin
          rw_n     = sda;
          state_n  = shreg[6:0] == SLAVE_ADDR ? ADDR_ACK : WAIT_STOP;
          busy_n   = busy | (shreg[6:0] == SLAVE_ADDR);
          tx_req_n = sda & (shreg[6:0] == SLAVE_ADDR);
        end
        WRITE: if (cnt == 4'd7) begin
          rx_data_n  = shreg_n;
          rx_valid_n = 1'b1;
          state_n    = WRITE_ACK;
        end
        READ_ACK: begin
          state_n  = sda ? WAIT_STOP : READ;
          tx_req_n = ~sda;
          cnt_n    = 4'd9;
        end
        default: ;
      endcase
    end else if (scl_fall) begin
      case (state)
        ADDR_ACK, WRITE_ACK: begin
          sda_oe_n = ~sda_oe | (state == ADDR_ACK & rw & ~tx_shift[7]);
          if (sda_oe) begin
            cnt_n   = 4'd0;
            state_n = (state == ADDR_ACK && rw) ? READ : WRITE;
          end
        end
        READ: begin
          sda_oe_n = cnt == 4'd9 ? ~tx_shift[7] : cnt == 4'd8 ? 1'b0 : ~tx_shift[6];
          cnt_n    = cnt == 4'd9 ? 4'd0 : cnt;
          state_n  = cnt == 4'd8 ? READ_ACK : READ;
          if (cnt < 4'd8) tx_shift_n = {tx_shift[6:0], 1'b0};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master driving i2c_slave, with table, directed and random transactions.
`timescale 1ns/1ps
module tb_i2c_slave;
  logic       clk = 1'b0, reset = 1'b1, scl = 1'b1, m_low = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy;
  wire        sda;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
    .clk(clk), .reset(reset), .i2c_scl(scl), .i2c_sda(sda),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_req(tx_req), .busy(busy)
  );

  always #5 clk = ~clk;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif
  localparam int Q = 8;

  int total = 0, bad = 0;
  int cyc = 0, rx_pulses = 0, rx_hi = 0, tx_pulses = 0, tx_hi = 0, busy_falls = 0, dut_low = 0;
  int rx_cyc = 0, tx_cyc = 0, sda_fall_cyc = 0, sda_rise_cyc = 0;
  int r_cyc[9], f_cyc[9];
  logic [7:0] rx_q[$];
  logic rv_p = 1'b0, tq_p = 1'b0, bz_p = 1'b0, sd_p = 1'b1;

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (rx_valid) rx_hi++;
    if (rx_valid && !rv_p) begin rx_pulses++; rx_cyc = cyc; rx_q.push_back(rx_data); end
    if (tx_req) tx_hi++;
    if (tx_req && !tq_p) begin tx_pulses++; tx_cyc = cyc; end
    if (!busy && bz_p) busy_falls++;
    if (!sda && !m_low) dut_low++;
    if (sda && !sd_p) sda_rise_cyc = cyc;
    if (!sda && sd_p) sda_fall_cyc = cyc;
    rv_p = rx_valid; tq_p = tx_req; bz_p = busy; sd_p = sda;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running after 1 ms");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_start;
    m_low = 1'b0; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    m_low = 1'b1; wait_clk(Q);
    scl = 1'b0;   wait_clk(Q);
  endtask

  task automatic bus_stop;
    m_low = 1'b1; wait_clk(Q);
    scl = 1'b1;   wait_clk(Q);
    m_low = 1'b0; wait_clk(2 * Q);
  endtask

  task automatic clk_bit(input logic b, input int idx, output logic r);
    m_low = !b; wait_clk(Q);
    scl = 1'b1; r_cyc[idx] = cyc; wait_clk(Q);
    r = sda;    wait_clk(Q);
    scl = 1'b0; f_cyc[idx] = cyc; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 0; i < 8; i++) clk_bit(d[7-i], i, r);
    clk_bit(1'b1, 8, r);
    ack = !r;
  endtask

  task automatic read_byte(input logic nack, input logic [7:0] nxt, output logic [7:0] d);
    logic r;
    for (int i = 0; i < 8; i++) begin clk_bit(1'b1, i, r); d[7-i] = r; end
    tx_data = nxt;
    clk_bit(nack, 8, r);
  endtask

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] data;
    logic       ack;
    int         rx_inc;
    logic [7:0] rd;
  } vec_t;

  initial begin
    vec_t tbl[4];
    logic       ack, ack2, r, m;
    logic [7:0] d;
    logic [6:0] a;
    logic [7:0] bytes[4];
    int n, rxp, txp, dl, bf;
    tbl[0] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1, 8'h00};
    tbl[1] = '{7'h51, 1'b0, 8'hA5, 1'b0, 0, 8'h00};
    tbl[2] = '{7'h50, 1'b1, 8'h3C, 1'b1, 0, 8'h3C};
    tbl[3] = '{7'h2A, 1'b1, 8'h99, 1'b0, 0, 8'hFF};

    wait_clk(3);
    chk("reset rx_data", rx_data, 8'h00);
    chk("reset busy", busy, 0);
    reset = 1'b0;
    wait_clk(4);
    chk("idle rx_valid", rx_valid, 0);
    chk("idle tx_req", tx_req, 0);
    chk("idle sda", sda, 1);

    for (int v = 0; v < 4; v++) begin
      rxp = rx_pulses; txp = tx_pulses; dl = dut_low;
      tx_data = tbl[v].data;
      bus_start;
      write_byte({tbl[v].addr, tbl[v].rw}, ack);
      chk($sformatf("vec%0d addr ack", v), ack, tbl[v].ack);
      chk($sformatf("vec%0d busy", v), busy, tbl[v].ack);
      if (!tbl[v].rw) begin
        write_byte(tbl[v].data, ack2);
        chk($sformatf("vec%0d data ack", v), ack2, tbl[v].ack);
        if (tbl[v].ack) begin
          chk("rx_valid latency", rx_cyc - r_cyc[7], LAT);
          chk("ack drive latency", sda_fall_cyc - f_cyc[7], LAT);
          chk("ack release latency", sda_rise_cyc - f_cyc[8], LAT);
          chk("rx_data", rx_q[$], tbl[v].data);
        end
      end else begin
        read_byte(1'b1, 8'h00, d);
        chk($sformatf("vec%0d read", v), d, tbl[v].rd);
      end
      bus_stop;
      chk($sformatf("vec%0d busy after stop", v), busy, 0);
      chk($sformatf("vec%0d rx pulses", v), rx_pulses - rxp, tbl[v].rx_inc);
      chk($sformatf("vec%0d tx pulses", v), tx_pulses - txp, int'(tbl[v].rw & tbl[v].ack));
      if (!tbl[v].ack) chk($sformatf("vec%0d sda never driven", v), dut_low - dl, 0);
    end
    chk("rx_valid one cycle", rx_hi, rx_pulses);
    chk("tx_req one cycle", tx_hi, tx_pulses);

    // read 3C with ACK, then C3 with NACK
    txp = tx_pulses;
    tx_data = 8'h3C;
    bus_start;
    write_byte(8'hA1, ack);
    chk("rd2 addr ack", ack, 1);
    read_byte(1'b0, 8'hC3, d);
    chk("rd2 byte0", d, 8'h3C);
    chk("tx_req continue latency", tx_cyc - r_cyc[8], LAT);
    read_byte(1'b1, 8'h00, d);
    chk("rd2 byte1", d, 8'hC3);
    chk("rd2 sda released", sda, 1);
    bus_stop;
    chk("rd2 tx pulses", tx_pulses - txp, 2);

    // write 12, repeated START, read 77
    rx_q.delete();
    bus_start;
    write_byte(8'hA0, ack);
    write_byte(8'h12, ack2);
    chk("rs write ack", ack & ack2, 1);
    chk("rs rx_data", rx_q.size() == 1 ? int'(rx_q[0]) : -1, 8'h12);
    bf = busy_falls;
    tx_data = 8'h77;
    bus_start;
    write_byte(8'hA1, ack);
    chk("rs read addr ack", ack, 1);
    read_byte(1'b1, 8'h00, d);
    chk("rs read byte", d, 8'h77);
    chk("rs busy held", busy_falls - bf, 0);
    chk("rs busy level", busy, 1);
    bus_stop;
    chk("rs busy drop", busy, 0);

    // asynchronous reset during the 4th data bit of a write
    rxp = rx_pulses;
    bus_start;
    write_byte(8'hA0, ack);
    for (int i = 0; i < 3; i++) clk_bit(1'b0, i, r);
    m_low = 1'b0; wait_clk(Q);
    scl = 1'b1; wait_clk(2);
    chk("pre-reset busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("reset busy immediate", busy, 0);
    chk("reset sda released", sda, 1);
    wait_clk(2);
    reset = 1'b0;
    wait_clk(Q);
    scl = 1'b0; wait_clk(Q);
    chk("reset no rx_valid", rx_pulses - rxp, 0);
    rx_q.delete();
    bus_start;
    write_byte(8'hA0, ack);
    write_byte(8'h5A, ack2);
    bus_stop;
    chk("post-reset acks", ack & ack2, 1);
    chk("post-reset rx", rx_q.size() == 1 ? int'(rx_q[0]) : -1, 8'h5A);

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    // 1-clk SDA low pulse with SCL high must not be taken as START
    dl = dut_low;
    m_low = 1'b1; wait_clk(1);
    m_low = 1'b0; wait_clk(2 * Q);
    scl = 1'b0; wait_clk(Q);
    write_byte(8'hA0, ack);
    chk("glitch no ack", ack, 0);
    chk("glitch busy", busy, 0);
    chk("glitch sda never driven", dut_low - dl, 0);
    bus_stop;
`endif

    // random transactions against a transaction-level model
    for (int t = 0; t < 10; t++) begin
      a = $urandom_range(0, 1) ? 7'h50 : 7'($urandom);
      m = (a == 7'h50);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) bytes[i] = 8'($urandom);
      r = 1'($urandom);
      rx_q.delete();
      txp = tx_pulses; dl = dut_low;
      tx_data = bytes[0];
      bus_start;
      write_byte({a, r}, ack);
      chk($sformatf("rnd%0d addr ack", t), ack, m);
      for (int i = 0; i < n; i++) begin
        if (!r) begin
          write_byte(bytes[i], ack2);
          chk($sformatf("rnd%0d wr ack%0d", t, i), ack2, m);
        end else begin
          read_byte(i == n - 1, bytes[i + 1], d);
          chk($sformatf("rnd%0d rd%0d", t, i), d, m ? bytes[i] : 8'hFF);
        end
      end
      bus_stop;
      chk($sformatf("rnd%0d rx count", t), rx_q.size(), (m && !r) ? n : 0);
      for (int i = 0; i < rx_q.size() && i < n; i++)
        chk($sformatf("rnd%0d rx%0d", t, i), rx_q[i], bytes[i]);
      chk($sformatf("rnd%0d tx_req count", t), tx_pulses - txp, (m && r) ? n : 0);
      if (!m) chk($sformatf("rnd%0d sda never driven", t), dut_low - dl, 0);
      chk($sformatf("rnd%0d busy", t), busy, 0);
    end
    chk("final rx_valid one cycle", rx_hi, rx_pulses);
    chk("final tx_req one cycle", tx_hi, tx_pulses);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
